biquad_cascade: RTL and testbench

Time-multiplexed cascade of SECTIONS direct-form-I biquad IIR sections sharing one signed multiplier-accumulator. Per-section coefficients live in a writable register file; per-section history is held internally. Samples enter and leave through valid/ready handshakes, so the block replaces chains of single-section filters in the audio/DSP datapath and tolerates a stalling downstream consumer. Arithmetic is two's complement throughout, with saturation and overflow reporting.

---
 rtl/biquad_cascade_if.sv | 23 ++
 rtl/biquad_cascade.sv | 168 ++++++++++++++++
 tb/tb_biquad_cascade.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/biquad_cascade_if.sv
// Sample stream bundle for biquad_cascade: input handshake, output handshake and saturation flag.
// The producer/consumer side uses master; the filter uses slave.
interface biquad_cascade_if #(
    parameter int DATAWIDTH = 12
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [DATAWIDTH-1:0] x_in;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [DATAWIDTH-1:0] y_out;
    logic                        out_sat;

    modport master (
        output in_valid, x_in, out_ready,
        input  in_ready, out_valid, y_out, out_sat
    );

    modport slave (
        input  in_valid, x_in, out_ready,
        output in_ready, out_valid, y_out, out_sat
    );
endinterface

// File: rtl/biquad_cascade.sv
// Cascade of DF-I biquads sharing one MAC; 6*SECTIONS cycles from accept to out_valid.
// Accepts only in IDLE; the result is held in OUT until out_ready, stalling new input.
module biquad_cascade #(
    parameter int DATAWIDTH = 12,
    parameter int COEFWIDTH = 16,
    parameter int SECTIONS  = 4,
    parameter int ACCUM     = 3,
    parameter int CAW       = $clog2(5*SECTIONS)
) (
    input  logic                        clk,
    input  logic                        nreset,
    biquad_cascade_if.slave             bus,
    input  logic                        clear,
    input  logic                        coef_we,
    input  logic [CAW-1:0]              coef_addr,
    input  logic signed [COEFWIDTH-1:0] coef_wdata,
    output logic                        busy
);
    localparam int ACCW  = DATAWIDTH + COEFWIDTH + ACCUM;
    localparam int PW    = DATAWIDTH + COEFWIDTH;
    localparam int NCOEF = 5 * SECTIONS;
    localparam int SW    = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;

    localparam logic signed [COEFWIDTH-1:0] B0_ONE = {2'b01, {(COEFWIDTH-2){1'b0}}};
    localparam logic signed [ACCW-1:0] YMAX = {{(ACCW-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] YMIN = {{(ACCW-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_t;

    state_t                        state;
    logic [SW-1:0]                 s;
    logic [2:0]                    k;
    logic signed [DATAWIDTH-1:0]   xin_s;
    logic signed [ACCW-1:0]        acc;
    logic                          sat;
    logic                          out_valid;
    logic signed [DATAWIDTH-1:0]   y_out;
    logic                          out_sat;

    logic signed [COEFWIDTH-1:0]   coef [NCOEF];
    logic signed [DATAWIDTH-1:0]   x1 [SECTIONS];
    logic signed [DATAWIDTH-1:0]   x2 [SECTIONS];
    logic signed [DATAWIDTH-1:0]   y1 [SECTIONS];
    logic signed [DATAWIDTH-1:0]   y2 [SECTIONS];

    logic [CAW-1:0]                cidx;
    logic signed [COEFWIDTH-1:0]   csel;
    logic signed [DATAWIDTH-1:0]   op;
    logic signed [PW-1:0]          prod;
    logic signed [ACCW-1:0]        acc_next;
    logic signed [ACCW-1:0]        r;
    logic signed [DATAWIDTH-1:0]   ycl;
    logic                          sat_now;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid;
    assign bus.y_out     = y_out;
    assign bus.out_sat   = out_sat;
    assign busy          = (state != IDLE);

    always_comb begin
        cidx = CAW'(int'(s) * 5 + int'(k));
        csel = coef[cidx];
        case (k)
            3'd1:    op = x1[s];
            3'd2:    op = x2[s];
            3'd3:    op = y1[s];
            3'd4:    op = y2[s];
            default: op = xin_s;
        endcase
        prod     = PW'(op) * PW'(csel);
        acc_next = (k == 3'd0) ? ACCW'(prod) : acc + ACCW'(prod);
    end

    // Floor-truncate the Q2 coefficient scaling back to sample scale, then clamp.
    always_comb begin
        r       = acc >>> (COEFWIDTH - 2);
        sat_now = 1'b0;
        ycl     = r[DATAWIDTH-1:0];
        if (r > YMAX) begin
            ycl     = {1'b0, {(DATAWIDTH-1){1'b1}}};
            sat_now = 1'b1;
        end else if (r < YMIN) begin
            ycl     = {1'b1, {(DATAWIDTH-1){1'b0}}};
            sat_now = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            s         <= '0;
            k         <= '0;
            xin_s     <= '0;
            acc       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            y_out     <= '0;
            out_sat   <= 1'b0;
            for (int i = 0; i < NCOEF; i++) coef[i] <= (i % 5 == 0) ? B0_ONE : '0;
            for (int i = 0; i < SECTIONS; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
        end else begin
            if (state == IDLE && coef_we && int'(coef_addr) < NCOEF)
                coef[coef_addr] <= coef_wdata;

            if (clear) begin
                for (int i = 0; i < SECTIONS; i++) begin
                    x1[i] <= '0;
                    x2[i] <= '0;
                    y1[i] <= '0;
                    y2[i] <= '0;
                end
                state     <= IDLE;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.in_valid) begin
                            xin_s <= bus.x_in;
                            s     <= '0;
                            k     <= '0;
                            sat   <= 1'b0;
                            state <= MAC;
                        end
                    end
                    MAC: begin
                        acc <= acc_next;
                        if (k == 3'd4) begin
                            k     <= '0;
                            state <= WB;
                        end else begin
                            k <= k + 3'd1;
                        end
                    end
                    WB: begin
                        x2[s] <= x1[s];
                        x1[s] <= xin_s;
                        y2[s] <= y1[s];
                        y1[s] <= ycl;
                        xin_s <= ycl;
                        if (sat_now) sat <= 1'b1;
                        if (int'(s) == SECTIONS - 1) begin
                            y_out     <= ycl;
                            out_sat   <= sat | sat_now;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end else begin
                            s     <= s + 1'b1;
                            state <= MAC;
                        end
                    end
                    OUT: begin
                        if (bus.out_ready) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_biquad_cascade.sv
// Directed bench for biquad_cascade: passthrough, FIR, IIR, saturation, backpressure and abort.
module tb_biquad_cascade;
    logic        clk = 1'b0;
    logic        nreset;
    logic        clear;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic        busy;
    int          errors = 0;
    int          checks = 0;

    biquad_cascade_if #(.DATAWIDTH(12)) bus();

    biquad_cascade dut (
        .clk        (clk),
        .nreset     (nreset),
        .bus        (bus.slave),
        .clear      (clear),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_coef(input logic [4:0] addr, input logic [15:0] val);
        coef_we = 1'b1; coef_addr = addr; coef_wdata = val;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic set_s0(input logic [15:0] b0, b1, b2, a1, a2);
        wr_coef(5'd0, b0); wr_coef(5'd1, b1); wr_coef(5'd2, b2);
        wr_coef(5'd3, a1); wr_coef(5'd4, a2);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Accepts one sample with out_ready high, checks result and 24-cycle latency.
    task automatic sample(input string tag, input logic [11:0] x, input logic [11:0] ey, input logic es);
        int n;
        bus.x_in = x; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(n);
        chk({tag, "_lat"}, n, 24);
        chk({tag, "_y"},   {20'd0, bus.y_out}, {20'd0, ey});
        chk({tag, "_sat"}, {31'd0, bus.out_sat}, {31'd0, es});
        @(posedge clk); #1;
    endtask

    initial begin
        int  n;
        logic seen;
        nreset = 1'b0; clear = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        bus.in_valid = 1'b0; bus.x_in = '0; bus.out_ready = 1'b1;
        #12;
        chk("rst_in_ready",  {31'd0, bus.in_ready},  1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_y_out",     {20'd0, bus.y_out},     0);
        chk("rst_out_sat",   {31'd0, bus.out_sat},   0);
        chk("rst_busy",      {31'd0, busy},          0);
        nreset = 1'b1;
        @(posedge clk); #1;

        sample("pass", 12'h3FF, 12'h3FF, 1'b0);

        set_s0(16'h2000, 16'h2000, 16'h0000, 16'h0000, 16'h0000);
        pulse_clear();
        sample("fir0", 12'h400, 12'h200, 1'b0);
        sample("fir1", 12'h000, 12'h200, 1'b0);
        sample("fir2", 12'h000, 12'h000, 1'b0);

        set_s0(16'h4000, 16'h0000, 16'h0000, 16'h2000, 16'h0000);
        pulse_clear();
        sample("iir0", 12'h400, 12'h400, 1'b0);
        sample("iir1", 12'h000, 12'h200, 1'b0);
        sample("iir2", 12'h000, 12'h100, 1'b0);
        sample("iir3", 12'h000, 12'h080, 1'b0);
        sample("iir4", 12'h000, 12'h040, 1'b0);

        set_s0(16'h6000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        pulse_clear();
        sample("satp", 12'h7FF, 12'h7FF, 1'b1);
        sample("satn", 12'h800, 12'h800, 1'b1);
        sample("nsat", 12'h100, 12'h180, 1'b0);

        // Stalled consumer; a coefficient write while busy must be dropped.
        bus.out_ready = 1'b0;
        bus.x_in = 12'h100; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wr_coef(5'd0, 16'h0000);
        wait_out(n);
        chk("bp_timeout", {31'd0, (n < 100)}, 1);
        repeat (10) begin @(posedge clk); #1; end
        chk("bp_y_hold",    {20'd0, bus.y_out},     12'h180);
        chk("bp_out_valid", {31'd0, bus.out_valid}, 1);
        chk("bp_in_ready",  {31'd0, bus.in_ready},  0);
        chk("bp_busy",      {31'd0, busy},          1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {31'd0, bus.in_ready}, 1);
        sample("bp_next", 12'h100, 12'h180, 1'b0);

        // clear together with in_valid in IDLE must not accept the sample.
        bus.x_in = 12'h123; bus.in_valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; clear = 1'b0;
        chk("clr_win_busy", {31'd0, busy}, 0);

        set_s0(16'h4000, 16'h0000, 16'h0000, 16'h2000, 16'h0000);
        pulse_clear();
        sample("abort_pre", 12'h400, 12'h400, 1'b0);
        bus.x_in = 12'h000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        chk("abort_busy", {31'd0, busy}, 1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("abort_in_ready", {31'd0, bus.in_ready}, 1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("abort_no_out", {31'd0, seen}, 0);
        sample("abort_r0", 12'h400, 12'h400, 1'b0);
        sample("abort_r1", 12'h000, 12'h200, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
